uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with an on-chip receive FIFO, used on the `ser_rx` pin of the hx8kdemo SoC. The block is a synthesizable successor to the fixed 8N1, 53-cycle-half-period serial sampler used on `ser_tx` in simulation. It adds:
- runtime-programmable bit period and configurable data width;
- false-start rejection and framing-error detection;
- a buffered ready/valid read port with overflow reporting.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `FIFO_DEPTH`, 16: receive FIFO entries, power of two, 2..256.
- `clk`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low).
- `ser_rx`  in  1  asynchronous serial input, idle high.
- `cfg_div`  in  16  clock cycles per bit; values below 4 are treated as 4.
- `rd_data`  out  DATA_BITS  head-of-FIFO word; valid while `rd_valid` is high.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer accepts; pop occurs on `rd_valid && rd_ready`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of stored words.
- `frame_err`  out  1  sticky: stop bit sampled low.
- `overflow`  out  1  sticky: word dropped because the FIFO was full.
- `err_clr`  in  1  one-cycle pulse; clears all sticky flags.

## Operation
- **Input synchronizer:** `ser_rx` passes through a 2-flop synchronizer; both flops reset to 1.
- **State machine states:** IDLE, START, DATA, [PARITY], STOP, BREAK.
- **IDLE:** on a synced 1→0 transition, latch `max(cfg_div,4)` as the frame divider, load the counter with floor(div/2), then go to START. A change on `cfg_div` mid-frame has no effect until the next frame.
- **START:** sample when the counter expires.
  - Sample = 1: false start; return to IDLE with nothing pushed.
  - Sample = 0: reload the counter with div and go to DATA.
- **DATA:** sample every div cycles and shift LSB-first: shreg = {rx, shreg[DATA_BITS-1:1]}. After DATA_BITS samples, go to PARITY if it is compiled in, else STOP.
- **STOP:** sample after div cycles.
  - Sample = 1: push shreg (and the parity result, if compiled in) and go to IDLE.
  - Sample = 0: set `frame_err`, discard the word, go to BREAK.
- **BREAK:** wait for synced rx = 1, then go to IDLE. A held-low line therefore yields exactly one `frame_err` and no words.
- **FIFO behaviour:** first-word fall-through.
  - Push when full: word dropped, `overflow` set.
  - Push and pop in the same cycle when full: both take effect, level unchanged, no overflow.
  - Pop when empty is impossible because `rd_valid` is 0.
- **Sticky flags:** `err_clr` clears them. If a set event and `err_clr` occur in the same cycle, the set wins.
- **Reset mid-frame:** FSM returns to IDLE, FIFO is emptied, partial word is lost, and the synchronizer is preset to idle.
- **Reset values:** `rd_valid`=0, `rd_data`=0, `fifo_level`=0, `frame_err`=0, `overflow`=0, `parity_err`=0.

## Timing
- Let E be the cycle in which the synced edge is detected, i.e. the pin falling edge + 2 cycles.
- Start sample: E + floor(div/2).
- Data bit k (k = 0..DATA_BITS-1): E + floor(div/2) + (k+1)·div.
- Parity bit (if compiled in): E + floor(div/2) + (DATA_BITS+1)·div.
- Stop bit: the slot after the last data or parity bit.
- Push occurs on the stop-sample clock edge. `rd_valid` and the incremented `fifo_level` are visible the following cycle.
- Pop is visible the cycle after `rd_valid && rd_ready`. The next word appears on `rd_data` in that same cycle.
- The next frame's start edge is accepted from the cycle after the stop sample. Back-to-back frames need no extra idle time.

## Configuration
- `UART_RX_PARITY_EN` defined: the block gains two ports.
  - `cfg_parity [1:0]` input: 00 = none, 01 = even, 10 = odd, 11 = none.
  - `parity_err` output: sticky, cleared by `err_clr`.
  - The PARITY state is present when `cfg_parity` selects even or odd. On a mismatch, `parity_err` is set, the word is discarded, and the FSM still checks the stop bit.
- `UART_RX_PARITY_EN` undefined: no `cfg_parity` or `parity_err` ports, no PARITY state; every frame is treated as no-parity.

## Test plan
- **Reset:** assert `resetn`=0 mid-frame → all outputs at reset values; the following frame 0x3C is received correctly.
- **Single frame:** `cfg_div`=106, 8N1 frame 0x55 → `rd_valid`=1 with `rd_data`=0x55 at stop sample + 1, `fifo_level`=1; pulse `rd_ready` → `rd_valid`=0.
- **False start:** drive `ser_rx` low for 20 cycles with `cfg_div`=106 → no push, `frame_err`=0, FSM back in IDLE.
- **Framing error and break:** frame 0xA3 with stop bit 0, then line held low for 3000 cycles → `frame_err`=1, `fifo_level`=0, no further flags; `err_clr` → `frame_err`=0.
- **Overflow:** `rd_ready`=0, 17 back-to-back frames 0x00..0x10 → `fifo_level`=16, `overflow`=1; drain reads 0x00..0x0F in order.
- **Parity (macro defined):** `cfg_parity`=01, send 0x07 with parity bit 0 → `parity_err`=1, no push; 0x07 with parity bit 1 → pushed, `parity_err` unchanged.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (runtime bit period, LSB-first, 1 stop bit) feeding a first-word
// fall-through receive FIFO. Define UART_RX_PARITY_EN to add even/odd parity checking.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ser_rx,
  input  logic [15:0]                   cfg_div,
`ifdef UART_RX_PARITY_EN
  input  logic [1:0]                    cfg_parity,
  output logic                          parity_err,
`endif
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  // Synchronizer plus one extra stage for falling-edge detection; all idle-high.
  logic rx_s1, rx_s2, rx_prev;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= ser_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  state_t               state, state_n;
  logic [15:0]          cnt, cnt_n, div_q, div_n, div_eff;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [3:0]           bit_cnt, bit_n;
  logic                 push, ferr_set, expire;
`ifdef UART_RX_PARITY_EN
  logic [1:0]           par_mode, par_mode_n;
  logic                 par_bad, par_bad_n, perr_set;
`endif

  assign div_eff = (cfg_div < 16'd4) ? 16'd4 : cfg_div;
  assign expire  = (cnt == 16'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div_q   <= 16'd4;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
      par_mode <= '0;
      par_bad  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_q   <= div_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_n;
`ifdef UART_RX_PARITY_EN
      par_mode <= par_mode_n;
      par_bad  <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_n    = div_q;
    shreg_n  = shreg;
    bit_n    = bit_cnt;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mode_n = par_mode;
    par_bad_n  = par_bad;
    perr_set   = 1'b0;
`endif
    case (state)
      S_IDLE: if (rx_prev && !rx_s2) begin
        // Divider (and parity mode) are frozen for the whole frame.
        div_n   = div_eff;
        cnt_n   = div_eff >> 1;
        bit_n   = '0;
        state_n = S_START;
`ifdef UART_RX_PARITY_EN
        par_mode_n = cfg_parity;
        par_bad_n  = 1'b0;
`endif
      end
      S_START: begin
        if (!expire) cnt_n = cnt - 16'd1;
        else if (rx_s2) state_n = S_IDLE;
        else begin
          cnt_n   = div_q;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (!expire) cnt_n = cnt - 16'd1;
        else begin
          shreg_n = {rx_s2, shreg[DATA_BITS-1:1]};
          cnt_n   = div_q;
          bit_n   = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_n = (^par_mode) ? S_PARITY : S_STOP;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!expire) cnt_n = cnt - 16'd1;
        else begin
          // Even: data^parity must be 0; odd: must be 1.
          par_bad_n = (^{shreg, rx_s2}) ^ par_mode[1];
          perr_set  = par_bad_n;
          cnt_n     = div_q;
          state_n   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!expire) cnt_n = cnt - 16'd1;
        else if (rx_s2) begin
`ifdef UART_RX_PARITY_EN
          push = !par_bad;
`else
          push = 1'b1;
`endif
          state_n = S_IDLE;
        end else begin
          ferr_set = 1'b1;
          state_n  = S_BREAK;
        end
      end
      S_BREAK: if (rx_s2) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Receive FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, pop, wr_en, ovf_set;

  assign full    = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign pop     = rd_valid && rd_ready;
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign rd_valid = (fifo_level != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= ferr_set || (frame_err && !err_clr);
      overflow  <= ovf_set  || (overflow  && !err_clr);
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_set || (parity_err && !err_clr);
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected words, a monitor
// pops and compares on every accepted read.
module tb_uart_rx_fifo;
  localparam int DB = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0, resetn = 1'b0, ser_rx = 1'b1, rd_ready = 1'b0, err_clr = 1'b0;
  logic [15:0]   cfg_div = 16'd106;
  logic [DB-1:0] rd_data;
  logic          rd_valid, frame_err, overflow;
  logic [4:0]    fifo_level;
`ifdef UART_RX_PARITY_EN
  logic [1:0]    cfg_parity = 2'b00;
  logic          parity_err;
`endif

  uart_rx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .ser_rx(ser_rx), .cfg_div(cfg_div),
`ifdef UART_RX_PARITY_EN
    .cfg_parity(cfg_parity), .parity_err(parity_err),
`endif
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .fifo_level(fifo_level), .frame_err(frame_err), .overflow(overflow),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0, n_bad = 0;
  bit            rdy_mode = 1'b0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Ideal transmitter: start bit, nb bits LSB-first, one stop bit of the given level.
  task automatic send_bits(input logic [9:0] b, input int nb, input logic stopb, input int div);
    ser_rx = 1'b0;
    tick(div);
    for (int i = 0; i < nb; i++) begin
      ser_rx = b[i];
      tick(div);
    end
    ser_rx = stopb;
    tick(div);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    rdy_mode = 1'b1;
    while (rd_valid && k < limit) begin tick(1); k++; end
    chk("drain_done", rd_valid, 1'b0);
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    rd_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (resetn && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_unexpected: got %0h expected none", rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", rd_data, mon_e);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int div;
    logic [DB-1:0] d;
    bit bad;
    tick(3);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    resetn = 1'b1;
    tick(2);

    // Single frame with push-timing window
    cfg_div = 16'd106;
    exp_q.push_back(8'h55);
    fork
      send_bits(10'h055, 8, 1'b1, 106);
      begin
        repeat (1009) @(negedge clk);
        chk("valid_before_stop", rd_valid, 1'b0);
        repeat (2) @(negedge clk);
        chk("valid_after_stop", rd_valid, 1'b1);
        chk("level_one", fifo_level, 5'd1);
        chk("head_word", rd_data, 8'h55);
      end
    join
    drain(200);

    // False start
    rdy_mode = 1'b0;
    ser_rx = 1'b0; tick(20); ser_rx = 1'b1; tick(120);
    chk("fs_level", fifo_level, 5'd0);
    chk("fs_ferr", frame_err, 1'b0);
    exp_q.push_back(8'h96);
    send_bits(10'h096, 8, 1'b1, 106);
    chk("fs_next_frame", fifo_level, 5'd1);
    drain(200);

    // Framing error followed by a long break
    send_bits(10'h0A3, 8, 1'b0, 106);
    tick(1500);
    chk("brk_ferr_set", frame_err, 1'b1);
    pulse_clr();
    chk("brk_ferr_clr", frame_err, 1'b0);
    tick(1500);
    chk("brk_single_ferr", frame_err, 1'b0);
    chk("brk_level", fifo_level, 5'd0);
    chk("brk_ovf", overflow, 1'b0);
    ser_rx = 1'b1; tick(5);

    // Divider clamp and divider change mid-frame
    cfg_div = 16'd1;
    exp_q.push_back(8'h5A);
    send_bits(10'h05A, 8, 1'b1, 4);
    cfg_div = 16'd20;
    exp_q.push_back(8'hC3);
    fork
      send_bits(10'h0C3, 8, 1'b1, 20);
      begin tick(30); cfg_div = 16'd50; end
    join
    cfg_div = 16'd20;
    tick(3);
    drain(200);

    // Overflow: 17 back-to-back frames, only the first 16 are kept
    rdy_mode = 1'b0;
    cfg_div = 16'd8;
    tick(2);
    for (int i = 0; i < 17; i++) begin
      if (i < DEPTH) exp_q.push_back(DB'(i));
      send_bits(10'(i), 8, 1'b1, 8);
    end
    tick(2);
    chk("ovf_level", fifo_level, 5'd16);
    chk("ovf_flag", overflow, 1'b1);
    drain(400);
    pulse_clr();
    chk("ovf_clr", overflow, 1'b0);

    // Reset mid-frame with a stored word
    rdy_mode = 1'b0;
    tick(2);
    send_bits(10'h011, 8, 1'b1, 8);
    tick(2);
    chk("pre_rst_level", fifo_level, 5'd1);
    ser_rx = 1'b0; tick(8 * 4);
    resetn = 1'b0; tick(2);
    chk("mid_rst_valid", rd_valid, 1'b0);
    chk("mid_rst_data", rd_data, 8'h00);
    chk("mid_rst_level", fifo_level, 5'd0);
    ser_rx = 1'b1; tick(1);
    resetn = 1'b1; tick(3);
    exp_q.push_back(8'h3C);
    send_bits(10'h03C, 8, 1'b1, 8);
    drain(200);

`ifdef UART_RX_PARITY_EN
    rdy_mode = 1'b0;
    cfg_parity = 2'b01;
    send_bits({2'b00, 8'h07}, 9, 1'b1, 16);
    tick(2);
    chk("par_err_set", parity_err, 1'b1);
    chk("par_no_push", fifo_level, 5'd0);
    exp_q.push_back(8'h07);
    send_bits({2'b01, 8'h07}, 9, 1'b1, 16);
    tick(2);
    chk("par_err_kept", parity_err, 1'b1);
    chk("par_push", fifo_level, 5'd1);
    cfg_parity = 2'b00;
    pulse_clr();
    chk("par_err_clr", parity_err, 1'b0);
    drain(200);
`endif

    // Randomized frames, dividers, bad stop bits and glitches
    rdy_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      div = int'($urandom_range(4, 24));
      cfg_div = 16'(div);
      d = DB'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        ser_rx = 1'b0; tick(1); ser_rx = 1'b1; tick(2 * div);
      end
      if (!bad) exp_q.push_back(d);
      send_bits(10'(d), 8, !bad, div);
      if (bad) begin
        ser_rx = 1'b1; tick(4);
        chk("rnd_ferr_set", frame_err, 1'b1);
        pulse_clr();
        chk("rnd_ferr_clr", frame_err, 1'b0);
      end else begin
        chk("rnd_ferr_quiet", frame_err, 1'b0);
      end
      tick(int'($urandom_range(0, 3)));
    end
    tick(4);
    drain(400);
    chk("end_ovf", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
